// File: rtl/eth_tx_frame_src_if.sv
// Bundle of command, MAC TX AXI-stream, PTP timestamp return and status signals
// for the transmit frame source.
interface eth_tx_frame_src_if #(
    parameter int LEN_WIDTH = 14
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic [7:0]           cmd_seed;
    logic [63:0]          tx_axis_tdata;
    logic [7:0]           tx_axis_tkeep;
    logic                 tx_axis_tlast;
    logic [16:0]          tx_axis_tuser;
    logic                 tx_axis_tvalid;
    logic                 tx_axis_tready;
    logic [95:0]          tx_ptp_ts;
    logic [15:0]          tx_ptp_ts_tag;
    logic                 tx_ptp_ts_valid;
    logic                 ts_out_valid;
    logic [95:0]          ts_out_ts;
    logic [15:0]          ts_out_tag;
    logic                 ts_out_mismatch;
    logic                 ts_unexpected;
    logic [2:0]           pending;

    modport master (
        output cmd_valid, cmd_len, cmd_seed, tx_axis_tready,
               tx_ptp_ts, tx_ptp_ts_tag, tx_ptp_ts_valid,
        input  cmd_ready, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser,
               tx_axis_tvalid, ts_out_valid, ts_out_ts, ts_out_tag, ts_out_mismatch,
               ts_unexpected, pending
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_seed, tx_axis_tready,
               tx_ptp_ts, tx_ptp_ts_tag, tx_ptp_ts_valid,
        output cmd_ready, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser,
               tx_axis_tvalid, ts_out_valid, ts_out_ts, ts_out_tag, ts_out_mismatch,
               ts_unexpected, pending
    );
endinterface

// File: rtl/eth_tx_frame_src.sv
// Generates tagged deterministic test frames into the MAC TX stream and pairs the
// egress timestamps the MAC returns with the outstanding frame tags.
module eth_tx_frame_src #(
    parameter int LEN_WIDTH   = 14,
    parameter int OUTSTANDING = 4
) (
    input  logic              tx_clk,
    input  logic              tx_rst_n,
    eth_tx_frame_src_if.slave bus
);
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t               state_r, state_s;
    logic                 run_r;
    logic [LEN_WIDTH-1:0] rem_r;
    logic [7:0]           base_r;
    logic [15:0]          tag_cnt_r, tag_r;
    logic [63:0]          tdata_r;
    logic [7:0]           tkeep_r;
    logic                 tlast_r, tvalid_r;
    logic [15:0]          fifo_r [OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 ts_valid_r, ts_mis_r, ts_unexp_r;
    logic [95:0]          ts_ts_r;
    logic [15:0]          ts_tag_r;

    logic                 cmd_ready_s, accept_s, beat_done_s, pop_s;
    logic [LEN_WIDTH-1:0] len_s, next_rem_s;
    logic [7:0]           next_base_s;
    logic [63:0]          beat_data_s;
    logic [7:0]           beat_keep_s;
    logic                 beat_last_s;

    assign len_s       = (bus.cmd_len == '0) ? LEN_WIDTH'(1) : bus.cmd_len;
    assign cmd_ready_s = run_r && (state_r == IDLE) && (count_r < CNT_W'(OUTSTANDING));
    assign accept_s    = bus.cmd_valid && cmd_ready_s;
    assign beat_done_s = tvalid_r && bus.tx_axis_tready;
    assign pop_s       = bus.tx_ptp_ts_valid && (count_r != '0);

    // FSM state register
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = SEND;
                else          state_s = IDLE;
            end
            SEND: begin
                if (beat_done_s && tlast_r) state_s = IDLE;
                else                        state_s = SEND;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next beat contents: first beat of a new frame in IDLE, following beat in SEND
    always_comb begin
        next_rem_s  = len_s;
        next_base_s = bus.cmd_seed;
        if (state_r == IDLE) begin
            next_rem_s  = len_s;
            next_base_s = bus.cmd_seed;
        end else begin
            next_rem_s  = rem_r - LEN_WIDTH'(8);
            next_base_s = base_r + 8'd8;
        end
        beat_data_s = 64'd0;
        beat_keep_s = 8'd0;
        for (int k = 0; k < 8; k++) begin
            if (LEN_WIDTH'(k) < next_rem_s) begin
                beat_keep_s[k]        = 1'b1;
                beat_data_s[8*k +: 8] = next_base_s + 8'(k);
            end else begin
                beat_keep_s[k]        = 1'b0;
                beat_data_s[8*k +: 8] = 8'd0;
            end
        end
        beat_last_s = (next_rem_s <= LEN_WIDTH'(8));
    end

    // Stream output registers; rem_r counts bytes from the presented beat to frame end
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            run_r     <= 1'b0;
            rem_r     <= '0;
            base_r    <= 8'd0;
            tag_cnt_r <= 16'd0;
            tag_r     <= 16'd0;
            tdata_r   <= 64'd0;
            tkeep_r   <= 8'd0;
            tlast_r   <= 1'b0;
            tvalid_r  <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (accept_s || (beat_done_s && !tlast_r)) begin
                rem_r    <= next_rem_s;
                base_r   <= next_base_s;
                tdata_r  <= beat_data_s;
                tkeep_r  <= beat_keep_s;
                tlast_r  <= beat_last_s;
                tvalid_r <= 1'b1;
            end else if (beat_done_s) begin
                tdata_r  <= 64'd0;
                tkeep_r  <= 8'd0;
                tlast_r  <= 1'b0;
                tvalid_r <= 1'b0;
            end
            if (accept_s) begin
                tag_r     <= tag_cnt_r;
                tag_cnt_r <= tag_cnt_r + 16'd1;
            end
        end
    end

    // Outstanding-tag FIFO
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < OUTSTANDING; i++) fifo_r[i] <= 16'd0;
        end else begin
            if (accept_s) begin
                fifo_r[wr_ptr_r] <= tag_cnt_r;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Timestamp match results, one cycle after the MAC strobe
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            ts_valid_r <= 1'b0;
            ts_unexp_r <= 1'b0;
            ts_mis_r   <= 1'b0;
            ts_ts_r    <= 96'd0;
            ts_tag_r   <= 16'd0;
        end else begin
            ts_valid_r <= pop_s;
            ts_unexp_r <= bus.tx_ptp_ts_valid && (count_r == '0);
            if (pop_s) begin
                ts_ts_r  <= bus.tx_ptp_ts;
                ts_tag_r <= fifo_r[rd_ptr_r];
                ts_mis_r <= (bus.tx_ptp_ts_tag != fifo_r[rd_ptr_r]);
            end
        end
    end

    assign bus.cmd_ready       = cmd_ready_s;
    assign bus.tx_axis_tdata   = tdata_r;
    assign bus.tx_axis_tkeep   = tkeep_r;
    assign bus.tx_axis_tlast   = tlast_r;
    assign bus.tx_axis_tuser   = {tag_r, 1'b0};
    assign bus.tx_axis_tvalid  = tvalid_r;
    assign bus.ts_out_valid    = ts_valid_r;
    assign bus.ts_out_ts       = ts_ts_r;
    assign bus.ts_out_tag      = ts_tag_r;
    assign bus.ts_out_mismatch = ts_mis_r;
    assign bus.ts_unexpected   = ts_unexp_r;
    assign bus.pending         = 3'(count_r);
endmodule

// File: tb/tb_eth_tx_frame_src.sv
// Bench for eth_tx_frame_src: a queue-based frame/tag model is compared with the DUT
// every cycle, with a few hand-computed literal expectations along the way.
module tb_eth_tx_frame_src;
    localparam int LW    = 14;
    localparam int DEPTH = 4;

    logic tx_clk   = 1'b0;
    logic tx_rst_n = 1'b0;
    always #5 tx_clk = ~tx_clk;

    eth_tx_frame_src_if #(.LEN_WIDTH(LW)) bus ();
    eth_tx_frame_src #(.LEN_WIDTH(LW), .OUTSTANDING(DEPTH)) dut (
        .tx_clk  (tx_clk),
        .tx_rst_n(tx_rst_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       beats[$];
    logic [15:0] m_fifo[$];
    int unsigned m_tag      = 0;
    logic [15:0] m_cur_tag  = 16'd0;
    logic        m_run      = 1'b0;
    logic        m_ts_valid = 1'b0;
    logic        m_ts_mis   = 1'b0;
    logic        m_unexp    = 1'b0;
    logic [95:0] m_ts       = 96'd0;
    logic [15:0] m_ts_tag   = 16'd0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return m_run && (beats.size() == 0) && (m_fifo.size() < DEPTH);
    endfunction

    // Frame as a byte sequence (seed+i) mod 256, cut into 8-byte beats
    function automatic void build_frame(input int len, input int seed);
        int    l, nb, idx;
        beat_t b;
        l  = (len == 0) ? 1 : len;
        nb = (l + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int k = 0; k < 8; k++) begin
                idx = bi * 8 + k;
                if (idx < l) begin
                    b.data[8*k +: 8] = 8'((seed + idx) % 256);
                    b.keep[k]        = 1'b1;
                end
            end
            b.last = (bi == nb - 1);
            beats.push_back(b);
        end
    endfunction

    task automatic compare_all();
        check("cmd_ready", bus.cmd_ready, model_ready());
        check("tvalid", bus.tx_axis_tvalid, beats.size() != 0);
        if (beats.size() != 0) begin
            check("tdata", bus.tx_axis_tdata, beats[0].data);
            check("tkeep", bus.tx_axis_tkeep, beats[0].keep);
            check("tlast", bus.tx_axis_tlast, beats[0].last);
            check("tuser", bus.tx_axis_tuser, {m_cur_tag, 1'b0});
        end
        check("pending", bus.pending, m_fifo.size());
        check("ts_out_valid", bus.ts_out_valid, m_ts_valid);
        if (m_ts_valid) begin
            check("ts_out_ts", bus.ts_out_ts, m_ts);
            check("ts_out_tag", bus.ts_out_tag, m_ts_tag);
            check("ts_out_mismatch", bus.ts_out_mismatch, m_ts_mis);
        end
        check("ts_unexpected", bus.ts_unexpected, m_unexp);
    endtask

    // Advance the model over the coming edge using the inputs currently driven
    task automatic model_update();
        logic acc, pop;
        if (!tx_rst_n) begin
            beats.delete();
            m_fifo.delete();
            m_tag      = 0;
            m_run      = 1'b0;
            m_ts_valid = 1'b0;
            m_unexp    = 1'b0;
        end else begin
            acc        = model_ready() && bus.cmd_valid;
            pop        = bus.tx_ptp_ts_valid && (m_fifo.size() != 0);
            m_unexp    = bus.tx_ptp_ts_valid && (m_fifo.size() == 0);
            m_ts_valid = pop;
            if (pop) begin
                m_ts_tag = m_fifo.pop_front();
                m_ts     = bus.tx_ptp_ts;
                m_ts_mis = (bus.tx_ptp_ts_tag != m_ts_tag);
            end
            if (beats.size() != 0 && bus.tx_axis_tready) void'(beats.pop_front());
            if (acc) begin
                build_frame(int'(bus.cmd_len), int'(bus.cmd_seed));
                m_cur_tag = m_tag[15:0];
                m_fifo.push_back(m_tag[15:0]);
                m_tag = (m_tag + 1) % 65536;
            end
            m_run = 1'b1;
        end
    endtask

    task automatic tick();
        model_update();
        @(negedge tx_clk);
        compare_all();
    endtask

    task automatic rand_ts(input bit rnd);
        bus.tx_ptp_ts_valid = 1'b0;
        if (rnd && $urandom_range(0, 3) == 0) begin
            bus.tx_ptp_ts_valid = 1'b1;
            bus.tx_ptp_ts       = {$urandom, $urandom, $urandom};
            if (m_fifo.size() != 0 && $urandom_range(0, 3) != 0) bus.tx_ptp_ts_tag = m_fifo[0];
            else bus.tx_ptp_ts_tag = 16'($urandom);
        end
    endtask

    // Issue a command and leave the bench in the cycle showing its first beat
    task automatic send_start(input int len, input logic [7:0] seed, input bit rnd);
        int budget = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        bus.cmd_seed  = seed;
        while (!model_ready() && budget < 300) begin
            rand_ts(rnd);
            tick();
            budget++;
        end
        if (budget >= 300) check("accept_timeout", 1'b0, 1'b1);
        rand_ts(rnd);
        tick();
        bus.cmd_valid       = 1'b0;
        bus.tx_ptp_ts_valid = 1'b0;
    endtask

    // Run until the last beat is presented; returns beats accepted so far
    task automatic drain_to_last(input bit rnd, output int nacc);
        int budget = 0;
        nacc = 0;
        while (beats.size() > 1 && budget < 2000) begin
            bus.tx_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.tx_axis_tready) nacc++;
            rand_ts(rnd);
            tick();
            budget++;
        end
        if (budget >= 2000) check("drain_timeout", 1'b0, 1'b1);
        bus.tx_axis_tready  = 1'b1;
        bus.tx_ptp_ts_valid = 1'b0;
    endtask

    task automatic finish_frame();
        bus.tx_axis_tready = 1'b1;
        tick();
    endtask

    task automatic ts_return(input logic [15:0] tag, input logic [95:0] ts);
        bus.tx_ptp_ts_valid = 1'b1;
        bus.tx_ptp_ts_tag   = tag;
        bus.tx_ptp_ts       = ts;
        tick();
        bus.tx_ptp_ts_valid = 1'b0;
    endtask

    task automatic drain_fifo();
        while (m_fifo.size() != 0) ts_return(m_fifo[0], {$urandom, $urandom, $urandom});
    endtask

    initial begin
        int          n;
        logic [15:0] t;
        bus.cmd_valid       = 1'b0;
        bus.cmd_len         = '0;
        bus.cmd_seed        = 8'd0;
        bus.tx_axis_tready  = 1'b1;
        bus.tx_ptp_ts       = 96'd0;
        bus.tx_ptp_ts_tag   = 16'd0;
        bus.tx_ptp_ts_valid = 1'b0;

        // Reset values
        @(negedge tx_clk);
        compare_all();
        tick();
        check("rst_tdata", bus.tx_axis_tdata, 64'd0);
        check("rst_tkeep", bus.tx_axis_tkeep, 8'd0);
        check("rst_tuser", bus.tx_axis_tuser, 17'd0);
        check("rst_ts_out_ts", bus.ts_out_ts, 96'd0);
        check("rst_ts_out_tag", bus.ts_out_tag, 16'd0);
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        tx_rst_n = 1'b1;
        tick();
        check("ready_after_reset", bus.cmd_ready, 1'b1);

        // len 64, seed 0x10
        send_start(64, 8'h10, 1'b0);
        check("f0_beat0", bus.tx_axis_tdata, 64'h1716151413121110);
        check("f0_tuser", bus.tx_axis_tuser, 17'h00000);
        check("f0_pending", bus.pending, 3'd1);
        drain_to_last(1'b0, n);
        check("f0_last_keep", bus.tx_axis_tkeep, 8'hFF);
        check("f0_beats", n + 1, 8);
        finish_frame();

        // len 13, seed 0xFE: byte wrap and partial last beat
        send_start(13, 8'hFE, 1'b0);
        check("f1_beat0", bus.tx_axis_tdata, 64'h050403020100FFFE);
        check("f1_tuser", bus.tx_axis_tuser, 17'h00002);
        finish_frame();
        check("f1_last_keep", bus.tx_axis_tkeep, 8'h1F);
        check("f1_last_data", bus.tx_axis_tdata, 64'h0000000A09080706);
        check("f1_tlast", bus.tx_axis_tlast, 1'b1);
        finish_frame();
        drain_fifo();

        // len 100 with random backpressure
        send_start(100, 8'($urandom), 1'b0);
        drain_to_last(1'b1, n);
        finish_frame();
        check("f2_beats", n + 1, 13);
        drain_fifo();

        // FIFO full: five single-beat commands with no timestamps
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(8);
        bus.cmd_seed  = 8'h33;
        for (int i = 0; i < 20; i++) tick();
        check("full_pending", bus.pending, 3'd4);
        check("full_ready", bus.cmd_ready, 1'b0);
        t = m_fifo[0];
        ts_return(t, 96'h123456789ABCDEF012345678);
        check("full_ts_valid", bus.ts_out_valid, 1'b1);
        check("full_ts_mis", bus.ts_out_mismatch, 1'b0);
        check("full_pending_pop", bus.pending, 3'd3);
        check("full_ready_after_pop", bus.cmd_ready, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        check("fifth_accepted", bus.pending, 3'd4);
        finish_frame();
        drain_fifo();

        // Tag mismatch, then a timestamp with nothing outstanding
        send_start(8, 8'h01, 1'b0);
        finish_frame();
        t = m_cur_tag;
        ts_return(t + 16'd7, 96'hA5);
        check("mis_flag", bus.ts_out_mismatch, 1'b1);
        check("mis_tag", bus.ts_out_tag, t);
        check("mis_pending", bus.pending, 3'd0);
        ts_return(16'd7, 96'h5A);
        check("unexp_pulse", bus.ts_unexpected, 1'b1);
        check("unexp_pending", bus.pending, 3'd0);
        tick();

        // Tag counter wrap
        force dut.tag_cnt_r = 16'hFFFF;
        m_tag = 32'hFFFF;
        tick();
        release dut.tag_cnt_r;
        send_start(3, 8'h20, 1'b0);
        check("wrap_tag_ffff", bus.tx_axis_tuser, 17'h1FFFE);
        finish_frame();
        send_start(3, 8'h21, 1'b0);
        check("wrap_tag_0000", bus.tx_axis_tuser, 17'h00000);
        finish_frame();
        drain_fifo();

        // Random mix of lengths (including 0), backpressure and timestamp returns
        for (int i = 0; i < 40; i++) begin
            send_start($urandom_range(0, 40), 8'($urandom), 1'b1);
            drain_to_last(1'b1, n);
            finish_frame();
        end
        drain_fifo();

        // Reset in the middle of a frame
        send_start(64, 8'h40, 1'b0);
        tick();
        tick();
        tx_rst_n = 1'b0;
        tick();
        check("midrst_tvalid", bus.tx_axis_tvalid, 1'b0);
        check("midrst_pending", bus.pending, 3'd0);
        tx_rst_n = 1'b1;
        tick();
        ts_return(16'd0, 96'h77);
        check("midrst_unexp", bus.ts_unexpected, 1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_frame_src.md
# eth_tx_frame_src

Transmit-side frame source and timestamp collector for the 64-bit Ethernet MAC path. On command, it generates a deterministic test frame on the MAC's TX AXI-stream input and tags each frame through `tx_axis_tuser`. It then consumes the PTP timestamps the MAC returns (`tx_ptp_ts`/`tx_ptp_ts_tag`/`tx_ptp_ts_valid`) and matches them against the outstanding tags, so every transmitted frame is paired with its egress timestamp.

## Interface
- `LEN_WIDTH`, 14: width of `cmd_len` in bytes; frame length 1..2^LEN_WIDTH-1.
- `OUTSTANDING`, 4: depth of the outstanding-tag FIFO; power of two, ≥2.
- `tx_clk`  in  1  clock; all logic on its rising edge.
- `tx_rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  frame request.
- `cmd_ready`  out  1  request accepted when `cmd_valid && cmd_ready`.
- `cmd_len`  in  LEN_WIDTH  frame length in bytes; 0 is treated as 1.
- `cmd_seed`  in  8  payload seed.
- `tx_axis_tdata`  out  64  payload; byte lane k = bits 8k+7:8k.
- `tx_axis_tkeep`  out  8  byte enables.
- `tx_axis_tlast`  out  1  last beat of frame.
- `tx_axis_tuser`  out  17  bit 0 = frame error (always 0); bits 16:1 = frame tag.
- `tx_axis_tvalid`  out  1  beat valid.
- `tx_axis_tready`  in  1  MAC accepts beat.
- `tx_ptp_ts`  in  96  egress timestamp from MAC.
- `tx_ptp_ts_tag`  in  16  tag of timestamped frame.
- `tx_ptp_ts_valid`  in  1  timestamp strobe, single cycle, no backpressure.
- `ts_out_valid`  out  1  matched-timestamp strobe.
- `ts_out_ts`  out  96  captured timestamp.
- `ts_out_tag`  out  16  expected tag (FIFO head).
- `ts_out_mismatch`  out  1  returned tag ≠ expected tag; qualified by `ts_out_valid`.
- `ts_unexpected`  out  1  pulse: timestamp arrived with no outstanding tag.
- `pending`  out  3  outstanding-tag count, 0..OUTSTANDING.

## Operation
- FSM states: IDLE, SEND.
  - IDLE: `cmd_ready = 1` iff `pending < OUTSTANDING`. This is combinational from registers and does not depend on `cmd_valid`.
  - On accept: latch length (0→1), seed, and the current tag. Push the tag into the FIFO, increment the tag counter (16-bit, wraps 0xFFFF→0x0000), and go to SEND.
  - SEND: `tx_axis_tvalid = 1`; `cmd_ready = 0`. Each `tvalid && tready` advances the beat counter. Acceptance of the `tlast` beat returns the FSM to IDLE.
- Beat count = ceil(len/8). Payload byte index i (0-based across frame) = (seed + i) mod 256.
- `tkeep` is 0xFF on non-last beats. On the last beat it is 0xFF if len mod 8 = 0, else (1 << (len mod 8)) − 1. Bytes with `tkeep` low are driven 0.
- `tuser[16:1]` holds the latched tag for all beats of the frame; `tuser[0]` = 0.
- While `tvalid && !tready`, the data, keep, last and user outputs are held stable.
- Timestamp return:
  - If `tx_ptp_ts_valid` and FIFO non-empty: pop the head, assert `ts_out_valid`, `ts_out_ts = tx_ptp_ts`, `ts_out_tag =` head, and `ts_out_mismatch = (tx_ptp_ts_tag != head)`.
  - If `tx_ptp_ts_valid` and FIFO empty: pulse `ts_unexpected`; the FIFO is untouched.
- Push and pop in the same cycle: `pending` is unchanged and FIFO order is preserved.
- Full FIFO: no new command is accepted until a pop. A pop in cycle N enables `cmd_ready` in N+1, never in N.

## Timing
- Reset values:
  - `cmd_ready = 0` during reset, 1 the first cycle after reset deasserts.
  - All `tx_axis_*` = 0, `ts_out_*` = 0, `ts_unexpected` = 0, `pending` = 0.
  - Tag counter = 0, FIFO empty, FSM in IDLE.
- Command accepted in cycle N → first beat `tvalid` in N+1. With `tready` held high, a frame of B beats occupies N+1..N+B, and the next command can be accepted in N+B+1, so there is one idle cycle between frames.
- `tx_ptp_ts_valid` in cycle M → `ts_out_valid`/`ts_unexpected` in cycle M+1, for one cycle. `pending` reflects the pop in M+1.
- Reset asserted mid-frame: `tvalid` is 0 after that edge and the frame is truncated without `tlast`. The FIFO and tag counter clear, and any later timestamps for those frames report `ts_unexpected`.

## Test plan
- Reset, then cmd len=64, seed=0x10, `tready` = 1 → 8 beats, beat0 `tdata` = 0x1716151413121110, last beat `tkeep` = 0xFF, `tuser` = 0x00000, `pending` = 1.
- len=13, seed=0xFE → 2 beats; beat0 bytes FE,FF,00..05; beat1 `tkeep` = 0x1F, upper 3 bytes 0, `tlast` = 1; tag 0 then next frame tag 1 (`tuser` = 0x00002).
- Random `tready` toggling on a len=100 frame → every accepted beat matches the model, outputs stable while stalled, exactly 13 beats.
- Issue 5 commands with no timestamps returned → 4 accepted, `cmd_ready` stays 0 with `pending` = 4. Return tag 0 → `ts_out_valid`, mismatch=0, `pending` 4→3, 5th command accepted the next cycle.
- Return `tx_ptp_ts_tag` = 7 while head = 1 → `ts_out_mismatch` = 1, `ts_out_tag` = 1, FIFO popped. Timestamp with empty FIFO → `ts_unexpected` pulse, `pending` stays 0.
- Preload tag counter to 0xFFFF via 65535 frames (or force), send two frames → tags 0xFFFF then 0x0000. Assert reset mid-frame → `tvalid` = 0 next cycle, `pending` = 0.
